// File: rtl/regfile_read_bypass.sv
// 16 x 16-bit register file with two decoded read ports and write-before-read
// bypass so a value being written is visible to same-cycle readers.
module regfile_read_bypass #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned NREG   = 16,
  parameter int unsigned ID_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ID_W-1:0]   SrcReg1,
  input  logic [ID_W-1:0]   SrcReg2,
  input  logic [ID_W-1:0]   DstReg,
  input  logic              WriteReg,
  input  logic [DATA_W-1:0] DstData,
  output logic [DATA_W-1:0] SrcData1,
  output logic [DATA_W-1:0] SrcData2,
  output logic              WriteHit1,
  output logic              WriteHit2
);

  logic [DATA_W-1:0] regs [NREG];
  logic [NREG-1:0]   rd_wl1;
  logic [NREG-1:0]   rd_wl2;
  logic [DATA_W-1:0] rd_data1;
  logic [DATA_W-1:0] rd_data2;
  logic              wr_en;

  // R0 is never written, so it stays at its reset value of zero.
  assign wr_en = WriteReg && (DstReg != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NREG); i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en) begin
      regs[DstReg] <= DstData;
    end
  end

  // One-hot read wordlines, ungated.
  assign rd_wl1 = NREG'(1) << SrcReg1;
  assign rd_wl2 = NREG'(1) << SrcReg2;

  always_comb begin
    rd_data1 = '0;
    rd_data2 = '0;
    for (int i = 0; i < int'(NREG); i++) begin
      if (rd_wl1[i]) rd_data1 = rd_data1 | regs[i];
      if (rd_wl2[i]) rd_data2 = rd_data2 | regs[i];
    end
  end

  // Bypass only on a real write; R0 reads never bypass.
  assign WriteHit1 = WriteReg && (DstReg == SrcReg1) && (SrcReg1 != '0);
  assign WriteHit2 = WriteReg && (DstReg == SrcReg2) && (SrcReg2 != '0);

  assign SrcData1 = WriteHit1 ? DstData : rd_data1;
  assign SrcData2 = WriteHit2 ? DstData : rd_data2;

endmodule

// File: tb/tb_regfile_read_bypass.sv
// Directed and random checks of regfile_read_bypass against hand-computed values
// and a shadow register model.
module tb_regfile_read_bypass;

  logic        clk;
  logic        rst;
  logic [3:0]  SrcReg1;
  logic [3:0]  SrcReg2;
  logic [3:0]  DstReg;
  logic        WriteReg;
  logic [15:0] DstData;
  logic [15:0] SrcData1;
  logic [15:0] SrcData2;
  logic        WriteHit1;
  logic        WriteHit2;

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] model [16];

  regfile_read_bypass dut (
    .clk(clk), .rst(rst),
    .SrcReg1(SrcReg1), .SrcReg2(SrcReg2),
    .DstReg(DstReg), .WriteReg(WriteReg), .DstData(DstData),
    .SrcData1(SrcData1), .SrcData2(SrcData2),
    .WriteHit1(WriteHit1), .WriteHit2(WriteHit2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shadow copy of architectural state, updated from the driven inputs.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) model[i] <= 16'h0;
    end else if (WriteReg && DstReg != 4'd0) begin
      model[DstReg] <= DstData;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one cycle's inputs mid-cycle; outputs are checked before the next rising edge.
  task automatic apply(input logic r, input logic we, input logic [3:0] dst,
                       input logic [15:0] data, input logic [3:0] s1, input logic [3:0] s2);
    @(negedge clk);
    rst = r; WriteReg = we; DstReg = dst; DstData = data;
    SrcReg1 = s1; SrcReg2 = s2;
    #1;
  endtask

  task automatic check_out(input string tag, input logic [15:0] d1, input logic h1,
                           input logic [15:0] d2, input logic h2);
    check({tag, ".d1"}, 32'(SrcData1), 32'(d1));
    check({tag, ".h1"}, 32'(WriteHit1), 32'(h1));
    check({tag, ".d2"}, 32'(SrcData2), 32'(d2));
    check({tag, ".h2"}, 32'(WriteHit2), 32'(h2));
  endtask

  initial begin
    rst = 1'b1; WriteReg = 1'b0; DstReg = 4'd0; DstData = 16'h0;
    SrcReg1 = 4'd0; SrcReg2 = 4'd0;

    // 1: reset, then every ID reads zero; DstReg/DstData junk with WriteReg=0
    apply(1'b1, 1'b0, 4'd0, 16'h0, 4'd0, 4'd0);
    for (int i = 0; i < 16; i++) begin
      apply(1'b0, 1'b0, 4'(i), 16'hDEAD, 4'(i), 4'(15 - i));
      check_out($sformatf("rst_id%0d", i), 16'h0, 1'b0, 16'h0, 1'b0);
    end

    // 2: write R5, read back on both ports, neighbours untouched
    apply(1'b0, 1'b1, 4'd5, 16'hBEEF, 4'd1, 4'd2);
    apply(1'b0, 1'b0, 4'd0, 16'h0, 4'd5, 4'd5);
    check_out("r5_read", 16'hBEEF, 1'b0, 16'hBEEF, 1'b0);
    apply(1'b0, 1'b0, 4'd0, 16'h0, 4'd4, 4'd6);
    check_out("r4_r6", 16'h0, 1'b0, 16'h0, 1'b0);

    // 3: same-cycle bypass on port 1 only
    apply(1'b0, 1'b1, 4'd3, 16'h0003, 4'd0, 4'd0);
    apply(1'b0, 1'b1, 4'd7, 16'h1234, 4'd7, 4'd3);
    check_out("bypass_p1", 16'h1234, 1'b1, 16'h0003, 1'b0);
    apply(1'b0, 1'b0, 4'd0, 16'h0, 4'd7, 4'd0);
    check_out("r7_stored", 16'h1234, 1'b0, 16'h0, 1'b0);

    // 4: writes to R0 are ignored and never bypass
    apply(1'b0, 1'b1, 4'd0, 16'hFFFF, 4'd0, 4'd0);
    check_out("r0_write", 16'h0, 1'b0, 16'h0, 1'b0);
    apply(1'b0, 1'b0, 4'd0, 16'h0, 4'd0, 4'd0);
    check_out("r0_after", 16'h0, 1'b0, 16'h0, 1'b0);

    // 5: write during reset is discarded, bypass still visible that cycle
    apply(1'b0, 1'b1, 4'd9, 16'hAAAA, 4'd0, 4'd0);
    apply(1'b1, 1'b1, 4'd9, 16'h5555, 4'd9, 4'd5);
    check_out("rst_write", 16'h5555, 1'b1, 16'hBEEF, 1'b0);
    apply(1'b0, 1'b0, 4'd0, 16'h0, 4'd9, 4'd5);
    check_out("r9_cleared", 16'h0, 1'b0, 16'h0, 1'b0);

    // 6: back-to-back writes to R15, both ports hitting the second one
    apply(1'b0, 1'b1, 4'd15, 16'h0001, 4'd0, 4'd15);
    check_out("r15_w1", 16'h0, 1'b0, 16'h0001, 1'b1);
    apply(1'b0, 1'b1, 4'd15, 16'h8000, 4'd15, 4'd15);
    check_out("r15_w2", 16'h8000, 1'b1, 16'h8000, 1'b1);
    apply(1'b0, 1'b0, 4'd15, 16'h1111, 4'd0, 4'd15);
    check_out("r15_st", 16'h0, 1'b0, 16'h8000, 1'b0);

    // Random traffic against the shadow model
    for (int c = 0; c < 1000; c++) begin
      logic        r, we, h1, h2;
      logic [3:0]  dst, s1, s2;
      logic [15:0] data, e1, e2;
      r    = ($urandom_range(0, 49) == 0);
      we   = 1'($urandom_range(0, 1));
      dst  = 4'($urandom_range(0, 15));
      data = 16'($urandom);
      s1   = ($urandom_range(0, 3) == 0) ? dst : 4'($urandom_range(0, 15));
      s2   = ($urandom_range(0, 3) == 0) ? dst : 4'($urandom_range(0, 15));
      apply(r, we, dst, data, s1, s2);
      h1 = we && (dst == s1) && (s1 != 4'd0);
      h2 = we && (dst == s2) && (s2 != 4'd0);
      e1 = h1 ? data : model[s1];
      e2 = h2 ? data : model[s2];
      check_out($sformatf("rnd%0d", c), e1, h1, e2, h2);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
